// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid bit, stall/flush, occupancy.
// Ports: clk, reset, data_in, valid_in, stall, flush -> data_out, valid_out, nop, occupancy
// Optional PIPE_STAGE_PERF_EN adds bubble_cnt[31:0] and flush_cnt[15:0].
module pipe_stage_reg #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      STAGES     = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter bit               STALL_MODE = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         valid_in,
  input  logic                         stall,
  input  logic                         flush,
  output logic [WIDTH-1:0]             data_out,
  output logic                         valid_out,
  output logic                         nop,
`ifdef PIPE_STAGE_PERF_EN
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [31:0]                  bubble_cnt,
  output logic [15:0]                  flush_cnt
`else
  output logic [$clog2(STAGES+1)-1:0]  occupancy
`endif
);

  localparam int unsigned OW = $clog2(STAGES+1);

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_n [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_n;
  logic [OW-1:0]     occ_q;
  logic [OW-1:0]     occ_n;
  logic              nop_q;
  logic              hold;
  logic              take;

  assign hold = stall && (STALL_MODE == 1'b0);
  assign take = valid_in && !stall;

  always_comb begin
    data_n = data_q;
    vld_n  = vld_q;
    if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        data_n[i] = BUBBLE_VAL;
      end
      vld_n = '0;
    end else if (!hold) begin
      // Bubble-mode stall lands here with take=0: slot 0 gets a bubble.
      data_n[0] = take ? data_in : BUBBLE_VAL;
      vld_n[0]  = take;
      for (int i = 1; i < STAGES; i++) begin
        data_n[i] = data_q[i-1];
        vld_n[i]  = vld_q[i-1];
      end
    end
  end

  always_comb begin
    occ_n = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_n = occ_n + OW'(vld_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= BUBBLE_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
      nop_q <= 1'b1;
    end else begin
      data_q <= data_n;
      vld_q  <= vld_n;
      occ_q  <= occ_n;
      nop_q  <= ~vld_n[STAGES-1];
    end
  end

  assign data_out  = data_q[STAGES-1];
  assign valid_out = vld_q[STAGES-1];
  assign nop       = nop_q;
  assign occupancy = occ_q;

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!valid_out && bubble_cnt != 32'hFFFF_FFFF) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (flush && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Table-driven bench for pipe_stage_reg across several configurations.
// Drives a shared input stream into four instances and checks each output.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        stall;
  logic        flush;

  logic [31:0] a_d, b_d, c_d, d_d;
  logic        a_v, b_v, c_v, d_v;
  logic        a_n, b_n, c_n, d_n;
  logic [1:0]  a_o, b_o, c_o;
  logic        d_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] a_bc;
  logic [15:0] a_fc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .STAGES(3),
    .BUBBLE_VAL(32'h1), .STALL_MODE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .data_out(a_d), .valid_out(a_v), .nop(a_n),
`ifdef PIPE_STAGE_PERF_EN
    .occupancy(a_o), .bubble_cnt(a_bc), .flush_cnt(a_fc)
`else
    .occupancy(a_o)
`endif
  );

  pipe_stage_reg #(.WIDTH(32), .STAGES(2),
    .BUBBLE_VAL(32'h1), .STALL_MODE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .data_out(b_d), .valid_out(b_v), .nop(b_n),
`ifdef PIPE_STAGE_PERF_EN
    .occupancy(b_o), .bubble_cnt(), .flush_cnt()
`else
    .occupancy(b_o)
`endif
  );

  pipe_stage_reg #(.WIDTH(32), .STAGES(2),
    .BUBBLE_VAL(32'h1), .STALL_MODE(1'b1)) dut_c (
    .clk(clk), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .data_out(c_d), .valid_out(c_v), .nop(c_n),
`ifdef PIPE_STAGE_PERF_EN
    .occupancy(c_o), .bubble_cnt(), .flush_cnt()
`else
    .occupancy(c_o)
`endif
  );

  pipe_stage_reg #(.WIDTH(32), .STAGES(1),
    .BUBBLE_VAL(32'h1), .STALL_MODE(1'b0)) dut_d (
    .clk(clk), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .data_out(d_d), .valid_out(d_v), .nop(d_n),
`ifdef PIPE_STAGE_PERF_EN
    .occupancy(d_o), .bubble_cnt(), .flush_cnt()
`else
    .occupancy(d_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic        st;
    logic        fl;
    logic [31:0] ad; logic av; int ao;
    logic [31:0] bd; logic bv; int bo;
    logic [31:0] cd; logic cv; int co;
    logic [31:0] dd; logic dv;
  } vec_t;

  vec_t vec [17];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step(logic r, logic v, logic [31:0] d,
                      logic st, logic fl);
    reset    = r;
    valid_in = v;
    data_in  = d;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(string t,
    logic [31:0] ad, logic av, int ao,
    logic [31:0] bd, logic bv, int bo,
    logic [31:0] cd, logic cv, int co);
    chk({t, " a.data"}, a_d, ad);
    chk({t, " a.valid"}, 32'(a_v), 32'(av));
    chk({t, " a.nop"}, 32'(a_n), 32'(!av));
    chk({t, " a.occ"}, 32'(a_o), ao);
    chk({t, " b.data"}, b_d, bd);
    chk({t, " b.valid"}, 32'(b_v), 32'(bv));
    chk({t, " b.nop"}, 32'(b_n), 32'(!bv));
    chk({t, " b.occ"}, 32'(b_o), bo);
    chk({t, " c.data"}, c_d, cd);
    chk({t, " c.valid"}, 32'(c_v), 32'(cv));
    chk({t, " c.nop"}, 32'(c_n), 32'(!cv));
    chk({t, " c.occ"}, 32'(c_o), co);
  endtask

  initial begin
    vec[0]  = '{1,0,32'h00,0,0, 1,0,0, 1,0,0, 1,0,0, 1,0};
    vec[1]  = '{1,0,32'h00,0,0, 1,0,0, 1,0,0, 1,0,0, 1,0};
    vec[2]  = '{0,1,32'h0A,0,0, 1,0,1, 1,0,1, 1,0,1, 32'h0A,1};
    vec[3]  = '{0,1,32'h0B,0,0, 1,0,2, 32'h0A,1,2,
                32'h0A,1,2, 32'h0B,1};
    vec[4]  = '{0,1,32'h0C,0,0, 32'h0A,1,3, 32'h0B,1,2,
                32'h0B,1,2, 32'h0C,1};
    vec[5]  = '{0,1,32'h0D,1,0, 32'h0A,1,3, 32'h0B,1,2,
                32'h0C,1,1, 32'h0C,1};
    vec[6]  = '{0,1,32'h0E,1,0, 32'h0A,1,3, 32'h0B,1,2,
                1,0,0, 32'h0C,1};
    vec[7]  = '{0,0,32'h0F,0,0, 32'h0B,1,2, 32'h0C,1,1,
                1,0,0, 1,0};
    vec[8]  = '{0,1,32'h11,0,0, 32'h0C,1,2, 1,0,1,
                1,0,1, 32'h11,1};
    vec[9]  = '{0,1,32'h22,0,0, 1,0,2, 32'h11,1,2,
                32'h11,1,2, 32'h22,1};
    vec[10] = '{0,1,32'h33,0,0, 32'h11,1,3, 32'h22,1,2,
                32'h22,1,2, 32'h33,1};
    vec[11] = '{0,1,32'h44,1,1, 1,0,0, 1,0,0, 1,0,0, 1,0};
    vec[12] = '{0,0,32'h55,0,0, 1,0,0, 1,0,0, 1,0,0, 1,0};
    vec[13] = '{0,1,32'h66,0,0, 1,0,1, 1,0,1, 1,0,1, 32'h66,1};
    vec[14] = '{0,1,32'h77,0,0, 1,0,2, 32'h66,1,2,
                32'h66,1,2, 32'h77,1};
    vec[15] = '{1,1,32'h88,0,0, 1,0,0, 1,0,0, 1,0,0, 1,0};
    vec[16] = '{0,0,32'h00,0,0, 1,0,0, 1,0,0, 1,0,0, 1,0};

    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    stall = 1'b0; flush = 1'b0;
    #1;

    for (int i = 0; i < 17; i++) begin
      string t;
      t = $sformatf("row%0d", i);
      step(vec[i].rst, vec[i].v, vec[i].d,
           vec[i].st, vec[i].fl);
      chk3(t, vec[i].ad, vec[i].av, vec[i].ao,
           vec[i].bd, vec[i].bv, vec[i].bo,
           vec[i].cd, vec[i].cv, vec[i].co);
      chk({t, " d.data"}, d_d, vec[i].dd);
      chk({t, " d.valid"}, 32'(d_v), 32'(vec[i].dv));
      chk({t, " d.nop"}, 32'(d_n), 32'(!vec[i].dv));
      chk({t, " d.occ"}, 32'(d_o), 32'(vec[i].dv));
    end

    // Stall across two cycles, then release and drain.
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    step(0, 1, 32'h0A, 0, 0);
    chk3("seq pushA", 1,0,1, 1,0,1, 1,0,1);
    step(0, 1, 32'h0B, 0, 0);
    chk3("seq pushB", 1,0,2, 32'h0A,1,2, 32'h0A,1,2);
    step(0, 1, 32'h0C, 1, 0);
    chk3("seq stall1", 1,0,2, 32'h0A,1,2, 32'h0B,1,1);
    step(0, 1, 32'h0C, 1, 0);
    chk3("seq stall2", 1,0,2, 32'h0A,1,2, 1,0,0);
    step(0, 1, 32'h0C, 0, 0);
    chk3("seq release", 32'h0A,1,3, 32'h0B,1,2, 1,0,1);
    step(0, 0, 32'h0, 0, 0);
    chk3("seq drain", 32'h0B,1,2, 32'h0C,1,1, 32'h0C,1,1);

`ifdef PIPE_STAGE_PERF_EN
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    chk("perf bc_reset", a_bc, 32'd0);
    chk("perf fc_reset", 32'(a_fc), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0, 0);
    chk("perf bc_idle10", a_bc, 32'd10);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 0, 1);
      step(0, 0, 32'h0, 0, 0);
    end
    chk("perf fc_3", 32'(a_fc), 32'd3);
    force dut_a.bubble_cnt = 32'hFFFF_FFFD;
    #1;
    release dut_a.bubble_cnt;
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 0);
    chk("perf bc_sat", a_bc, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
